// File: rtl/sine_pkg.sv
// Shared types, table geometry and the start-index rule used by the sine
// generators that read the common half-sine table.
package sine_pkg;

  localparam int SINE_SIZE  = 8;
  localparam int TABLE_SIZE = 32;
  localparam int PHASE_SIZE = 6;
  localparam int ADDR_W     = $clog2(TABLE_SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} sched_state_t;
  typedef enum logic {FWD, REV} dir_t;

  // Maps a signed phase onto the table around its midpoint; division truncates toward zero.
  function automatic logic [ADDR_W-1:0] calc_start_index(input logic signed [PHASE_SIZE-1:0] phase);
    int p;
    int s;
    int r;
    p = int'(phase);
    s = (p * (TABLE_SIZE - 1)) / ((1 << PHASE_SIZE) - 1);
    r = ((TABLE_SIZE - 1) / 2 + s) % TABLE_SIZE;
    if (r < 0) r += TABLE_SIZE;
    return ADDR_W'(r);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requesting channel after last_i,
// wrapping around; any_o flags that at least one channel requests.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              any_o
);

  // Scan from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (req_i[CH_W'((int'(last_i) + i) % NUM_CH)]) begin
        grant_o = CH_W'((int'(last_i) + i) % NUM_CH);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sine_channel_scheduler.sv
// Shares one half-sine table among NUM_CH channels: round-robin issue of one
// table read per sample, each channel bouncing its own index between the ends.
module sine_channel_scheduler
  import sine_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [CH_W-1:0]              cfg_ch_i,
  input  logic signed [PHASE_SIZE-1:0] cfg_phase_i,
  input  logic                         cfg_enable_i,
  output logic [ADDR_W-1:0]            tbl_addr_o,
  input  logic [SINE_SIZE-1:0]         tbl_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [CH_W-1:0]              out_ch_o,
  output logic [SINE_SIZE-1:0]         out_sample_o
);

  sched_state_t         state_q, state_d;
  logic [NUM_CH-1:0]    en_q, en_d;
  logic [ADDR_W-1:0]    idx_q [NUM_CH];
  logic [ADDR_W-1:0]    idx_d [NUM_CH];
  dir_t                 dir_q [NUM_CH];
  dir_t                 dir_d [NUM_CH];
  logic [CH_W-1:0]      last_q, last_d;
  logic [CH_W-1:0]      out_ch_q, out_ch_d;
  logic [SINE_SIZE-1:0] out_sample_q, out_sample_d;
  logic                 out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]    tbl_addr_q;
  logic [CH_W-1:0]      grant;
  logic                 any_en;
  logic                 issue;

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req_i   (en_q),
    .last_i  (last_q),
    .grant_o (grant),
    .any_o   (any_en)
  );

  assign issue = (state_q == ISSUE) && any_en;
  // Blocking config for the granted channel keeps its reload from racing its advance.
  assign cfg_ready_o  = !(issue && (cfg_ch_i == grant));
  assign tbl_addr_o   = issue ? idx_q[grant] : tbl_addr_q;
  assign out_valid_o  = out_valid_q;
  assign out_ch_o     = out_ch_q;
  assign out_sample_o = out_sample_q;

  always_comb begin
    // NOTE: every next-state value starts from its current value so no path can infer a latch.
    state_d      = state_q;
    en_d         = en_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    last_d       = last_q;
    out_valid_d  = out_valid_q;
    out_ch_d     = out_ch_q;
    out_sample_d = out_sample_q;

    unique case (state_q)
      IDLE: if (|en_q) state_d = ISSUE;
      ISSUE: begin
        if (any_en) begin
          out_sample_d = tbl_data_i;
          out_ch_d     = grant;
          out_valid_d  = 1'b1;
          last_d       = grant;
          state_d      = HOLD;
          if (dir_q[grant] == FWD) begin
            if (idx_q[grant] == ADDR_W'(TABLE_SIZE - 1)) begin
              dir_d[grant] = REV;
              idx_d[grant] = idx_q[grant] - ADDR_W'(1);
            end else begin
              idx_d[grant] = idx_q[grant] + ADDR_W'(1);
            end
          end else begin
            if (idx_q[grant] == '0) begin
              dir_d[grant] = FWD;
              idx_d[grant] = idx_q[grant] + ADDR_W'(1);
            end else begin
              idx_d[grant] = idx_q[grant] - ADDR_W'(1);
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = (|en_q) ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Out-of-range channel ids match no entry and are silently dropped.
    if (cfg_valid_i && cfg_ready_o) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_ch_i == CH_W'(c)) begin
          en_d[c]  = cfg_enable_i;
          idx_d[c] = calc_start_index(cfg_phase_i);
          dir_d[c] = cfg_phase_i[PHASE_SIZE-1] ? REV : FWD;
        end
      end
    end
  end

  // NOTE: non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      en_q         <= '0;
      last_q       <= CH_W'(NUM_CH - 1);
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_sample_q <= '0;
      tbl_addr_q   <= '0;
      // NOTE: per-channel state is a few flops rather than a RAM, so it is reset like any register.
      for (int c = 0; c < NUM_CH; c++) begin
        idx_q[c] <= '0;
        dir_q[c] <= FWD;
      end
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      last_q       <= last_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_sample_q <= out_sample_d;
      tbl_addr_q   <= tbl_addr_o;
    end
  end

endmodule

// File: tb/tb_sine_channel_scheduler.sv
// Directed bench for sine_channel_scheduler: a transaction-level channel model
// predicts every emitted sample; directed steps pin sequences to literal lists.
module tb_sine_channel_scheduler;
  import sine_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int T2_IDX [19] = '{15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 30, 29};
  localparam int T3A_IDX [3] = '{0, 1, 2};
  localparam int T3B_IDX [3] = '{30, 31, 30};
  localparam int T4_CH [8]   = '{0, 1, 2, 3, 0, 1, 2, 3};

  typedef struct {int ch; int sample; int cyc;} smp_t;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         cfg_valid = 1'b0;
  logic                         cfg_ready;
  logic [CH_W-1:0]              cfg_ch = '0;
  logic signed [PHASE_SIZE-1:0] cfg_phase = '0;
  logic                         cfg_enable = 1'b0;
  logic [ADDR_W-1:0]            tbl_addr;
  logic [SINE_SIZE-1:0]         tbl_data;
  logic                         out_valid;
  logic                         out_ready = 1'b0;
  logic [CH_W-1:0]              out_ch;
  logic [SINE_SIZE-1:0]         out_sample;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   hs_count = 0;
  smp_t q [$];

  // Model state: per-channel enable, index and step (+1/-1), plus last grant.
  bit   m_en [NUM_CH];
  int   m_idx [NUM_CH];
  int   m_step [NUM_CH];
  int   m_last;
  bit   pend_v;
  int   pend_ch, pend_ph;
  bit   pend_en;
  bit   prev_valid, prev_ready;
  int   prev_ch, prev_sample;
  int   g, c, nxt;

  sine_channel_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_ch_i     (cfg_ch),
    .cfg_phase_i  (cfg_phase),
    .cfg_enable_i (cfg_enable),
    .tbl_addr_o   (tbl_addr),
    .tbl_data_i   (tbl_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_ch_o     (out_ch),
    .out_sample_o (out_sample)
  );

  // Stand-in table: unique per address so the index behind a sample is recoverable.
  function automatic logic [SINE_SIZE-1:0] rom(input logic [ADDR_W-1:0] a);
    return SINE_SIZE'(int'(a) * 8 + 1);
  endfunction

  function automatic int start_idx(input int ph);
    int s;
    int r;
    s = ph * 31 / 63;
    r = (15 + s) % 32;
    if (r < 0) r += 32;
    return r;
  endfunction

  assign tbl_data = rom(tbl_addr);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are settled at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_en[k] = 1'b0; m_idx[k] = 0; m_step[k] = 1;
      end
      m_last = NUM_CH - 1;
      pend_v = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        g = -1;
        for (int i = 1; i <= NUM_CH; i++) begin
          c = (m_last + i) % NUM_CH;
          if (g < 0 && m_en[c]) g = c;
        end
        q.push_back('{ch: int'(out_ch), sample: int'(out_sample), cyc: cyc});
        if (g < 0) begin
          check("spurious_sample", 1, 0);
        end else begin
          check("model_ch", int'(out_ch), g);
          check("model_sample", int'(out_sample), int'(rom(ADDR_W'(m_idx[g]))));
          m_last = g;
          nxt = m_idx[g] + m_step[g];
          if (nxt < 0 || nxt > TABLE_SIZE - 1) begin
            m_step[g] = -m_step[g];
            nxt = m_idx[g] + m_step[g];
          end
          m_idx[g] = nxt;
        end
      end
      if (prev_valid && !prev_ready) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_ch", int'(out_ch), prev_ch);
        check("stall_sample", int'(out_sample), prev_sample);
      end
      if (out_valid) check("tbl_addr_hold", int'(rom(tbl_addr)), int'(out_sample));
      if (out_valid && out_ready) hs_count++;
      if (pend_v && pend_ch < NUM_CH) begin
        m_en[pend_ch]   = pend_en;
        m_idx[pend_ch]  = start_idx(pend_ph);
        m_step[pend_ch] = (pend_ph < 0) ? -1 : 1;
      end
      pend_v = cfg_valid && cfg_ready;
      pend_ch = int'(cfg_ch);
      pend_ph = int'(cfg_phase);
      pend_en = cfg_enable;
      prev_valid  = out_valid;
      prev_ready  = out_ready;
      prev_ch     = int'(out_ch);
      prev_sample = int'(out_sample);
    end
  end

  task automatic do_cfg(input int ch, input int ph, input bit en);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_phase = PHASE_SIZE'(ph); cfg_enable = en;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("cfg_accept_timeout", 0, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_samples(input int n, input string name);
    for (int k = 0; k < 400 && q.size() < n; k++) @(negedge clk);
    if (q.size() < n) check(name, q.size(), n);
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
    if (!out_valid) check(name, 0, 1);
  endtask

  task automatic drain();
    int quiet;
    quiet = 0;
    for (int k = 0; k < 100 && quiet < 4; k++) begin
      @(negedge clk);
      quiet = out_valid ? 0 : quiet + 1;
    end
    if (quiet < 4) check("drain_timeout", quiet, 4);
    q.delete();
  endtask

  initial begin
    int hs0;
    int n_at;
    int n_ch2;
    int n_vis;

    // 1: reset with random inputs, then release into IDLE
    for (int k = 0; k < 5; k++) begin
      cfg_valid  = 1'($urandom_range(0, 1));
      cfg_ch     = CH_W'($urandom);
      cfg_phase  = PHASE_SIZE'($urandom);
      cfg_enable = 1'($urandom_range(0, 1));
      out_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_cfg_ready", int'(cfg_ready), 1);
      check("rst_tbl_addr", int'(tbl_addr), 0);
      check("rst_out_ch", int'(out_ch), 0);
      check("rst_out_sample", int'(out_sample), 0);
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0; cfg_enable = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_after_reset", int'(out_valid), 0);
    end

    // 2: single channel, phase 0, full-rate stream with bounce at the top
    q.delete();
    do_cfg(0, 0, 1'b1);
    wait_samples(19, "t2_timeout");
    for (int i = 0; i < 19 && i < q.size(); i++) begin
      check("t2_ch", q[i].ch, 0);
      check("t2_sample", q[i].sample, T2_IDX[i] * 8 + 1);
      if (i > 0) check("t2_gap", q[i].cyc - q[i-1].cyc, 2);
    end
    do_cfg(0, 0, 1'b0);
    drain();

    // 3a: phase -32 starts at 0 running in reverse, bounces at the bottom
    do_cfg(1, -32, 1'b1);
    wait_samples(3, "t3a_timeout");
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      check("t3a_ch", q[i].ch, 1);
      check("t3a_sample", q[i].sample, T3A_IDX[i] * 8 + 1);
    end
    do_cfg(1, 0, 1'b0);
    drain();

    // 3b: phase 31 starts at 30 forward; then disable the held channel
    do_cfg(1, 31, 1'b1);
    wait_samples(3, "t3b_timeout");
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      check("t3b_ch", q[i].ch, 1);
      check("t3b_sample", q[i].sample, T3B_IDX[i] * 8 + 1);
    end
    @(posedge clk); #1; out_ready = 1'b0;
    wait_valid("t3b_hold_timeout");
    hs0 = hs_count;
    do_cfg(1, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("held_delivered", hs_count - hs0, 1);
    check("idle_after_held", int'(out_valid), 0);
    q.delete();

    // 4/5: all channels, long stall with reconfig of the held channel, then ch2 off
    @(posedge clk); #1; out_ready = 1'b0;
    do_cfg(0, 0, 1'b1);
    wait_valid("t4_first_timeout");
    do_cfg(1, 0, 1'b1);
    do_cfg(2, 0, 1'b1);
    do_cfg(3, 0, 1'b1);
    do_cfg(0, 31, 1'b1);
    repeat (5) @(negedge clk);
    check("t5_stall_valid", int'(out_valid), 1);
    check("t5_stall_ch", int'(out_ch), 0);
    check("t5_stall_sample", int'(out_sample), 121);
    @(posedge clk); #1; out_ready = 1'b1;
    wait_samples(8, "t4_timeout");
    for (int i = 0; i < 8 && i < q.size(); i++) check("t4_rr_ch", q[i].ch, T4_CH[i]);
    if (q.size() >= 5) begin
      check("t4_ch1_sample", q[1].sample, 121);
      check("t4_reloaded_ch0", q[4].sample, 241);
    end
    do_cfg(2, 0, 1'b0);
    n_at = q.size();
    wait_samples(n_at + 7, "t4_after_disable_timeout");
    n_ch2 = 0;
    for (int i = n_at; i < n_at + 7 && i < q.size(); i++) if (q[i].ch == 2) n_ch2++;
    check("t4_no_ch2_after_disable", n_ch2, 0);
    do_cfg(0, 0, 1'b0);
    do_cfg(1, 0, 1'b0);
    do_cfg(3, 0, 1'b0);
    drain();

    // 6: asynchronous reset during HOLD
    do_cfg(0, 0, 1'b1);
    do_cfg(1, 0, 1'b1);
    @(posedge clk); #1; out_ready = 1'b0;
    wait_valid("t6_hold_timeout");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", int'(out_valid), 0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    n_vis = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) n_vis++;
    end
    check("t6_silent_after_reset", n_vis, 0);
    do_cfg(3, 0, 1'b1);
    wait_samples(1, "t6_restart_timeout");
    if (q.size() >= 1) begin
      check("t6_restart_ch", q[0].ch, 3);
      check("t6_restart_sample", q[0].sample, 121);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
